// File: rtl/ahb_master_requester_if.sv
// Bundle between the AHB master requester, its local client and the bus/arbiter.
// The master modport is the requester's own view of the bundle.
interface ahb_master_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [2:0]            cmd_burst;
  logic [4:0]            cmd_len;
  logic                  hreq;
  logic                  hgrant;
  logic                  hwait;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hburst;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic                  wdata_pop;
  logic [DATA_WIDTH-1:0] rdata_out;
  logic                  rdata_valid;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_len,
    input  hgrant, hwait, hrdata, wdata_in,
    output cmd_ready, hreq, haddr, htrans, hwrite, hburst, hsize, hwdata,
    output wdata_pop, rdata_out, rdata_valid, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_len,
    output hgrant, hwait, hrdata, wdata_in,
    input  cmd_ready, hreq, haddr, htrans, hwrite, hburst, hsize, hwdata,
    input  wdata_pop, rdata_out, rdata_valid, done
  );
endinterface

// File: rtl/ahb_master_requester.sv
// AHB master request/transfer engine: takes one burst command, requests the bus,
// issues pipelined NONSEQ/SEQ address phases and tracks the trailing data phase.
module ahb_master_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                   hclk_i,
  input logic                   hreset_i,
  ahb_master_requester_if.master bus
);
  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // REQ   | hreq raised, waiting for grant
  // BURST | presenting address phases, counting accepted beats
  // TAIL  | last address accepted, waiting for final data phase
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_TAIL} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            burst_q, burst_d;
  logic [4:0]            remain_q, remain_d;
  logic                  first_q, first_d;
  logic                  dphase_q, dphase_d;
  logic                  dphase_write_q, dphase_write_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  dphase_done;
  logic                  hreq_c;
  logic [1:0]            htrans_c;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] addr_next;

  function automatic logic [4:0] beats_of(input logic [2:0] burst, input logic [4:0] len);
    case (burst)
      3'd0:          beats_of = 5'd1;
      3'd1:          beats_of = (len == 5'd0) ? 5'd1 : ((len > 5'd16) ? 5'd16 : len);
      3'd2, 3'd3:    beats_of = 5'd4;
      3'd4, 3'd5:    beats_of = 5'd8;
      default:       beats_of = 5'd16;
    endcase
  endfunction

  always_comb begin
    wrap_mask = '0;
    case (burst_q)
      3'd2:    wrap_mask = ADDR_WIDTH'(32'h0F);
      3'd4:    wrap_mask = ADDR_WIDTH'(32'h1F);
      3'd6:    wrap_mask = ADDR_WIDTH'(32'h3F);
      default: wrap_mask = '0;
    endcase
  end

  assign addr_inc  = addr_q + ADDR_WIDTH'(4);
  // WRAP bursts keep the upper address bits and roll only inside the wrap window.
  assign addr_next = (wrap_mask != '0) ? ((addr_q & ~wrap_mask) | (addr_inc & wrap_mask))
                                       : addr_inc;

  assign accept      = (state_q == S_BURST) & bus.hgrant & ~bus.hwait;
  assign dphase_done = dphase_q & ~bus.hwait;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    burst_d   = burst_q;
    remain_d  = remain_q;
    first_d   = first_q;
    hreq_c    = 1'b0;
    htrans_c  = TRANS_IDLE;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          write_d  = bus.cmd_write;
          burst_d  = bus.cmd_burst;
          remain_d = beats_of(bus.cmd_burst, bus.cmd_len);
          first_d  = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        hreq_c = 1'b1;
        if (bus.hgrant) state_d = S_BURST;
      end
      S_BURST: begin
        hreq_c   = 1'b1;
        htrans_c = first_q ? TRANS_NONSEQ : TRANS_SEQ;
        if (accept) begin
          first_d  = 1'b0;
          remain_d = remain_q - 5'd1;
          if (remain_q == 5'd1) state_d = S_TAIL;
          else                  addr_d  = addr_next;
        end
      end
      S_TAIL: begin
        if (dphase_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dphase_d       = dphase_q;
    dphase_write_d = dphase_write_q;
    if (accept) begin
      dphase_d       = 1'b1;
      dphase_write_d = write_q;
    end else if (!bus.hwait) begin
      dphase_d       = 1'b0;
    end
    done_d = (state_q == S_TAIL) & dphase_done;
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      write_q        <= 1'b0;
      burst_q        <= 3'd0;
      remain_q       <= 5'd0;
      first_q        <= 1'b0;
      dphase_q       <= 1'b0;
      dphase_write_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      burst_q        <= burst_d;
      remain_q       <= remain_d;
      first_q        <= first_d;
      dphase_q       <= dphase_d;
      dphase_write_q <= dphase_write_d;
      done_q         <= done_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.hreq        = hreq_c;
  assign bus.htrans      = htrans_c;
  assign bus.haddr       = addr_q;
  assign bus.hwrite      = write_q;
  assign bus.hburst      = burst_q;
  assign bus.hsize       = 3'b010;
  assign bus.hwdata      = (dphase_q & dphase_write_q) ? bus.wdata_in : '0;
  assign bus.wdata_pop   = dphase_done & dphase_write_q;
  assign bus.rdata_valid = dphase_done & ~dphase_write_q;
  assign bus.rdata_out   = bus.hrdata;
  assign bus.done        = done_q;
endmodule

// File: doc/ahb_master_requester.md
Name: ahb_master_requester

Overview:
Master-side request/transfer engine for the generated AHB interconnect; it is the initiator counterpart of the per-slave arbiter. It accepts one burst command at a time from a local client and raises hreq. After the arbiter grants, it issues the pipelined AHB address/data phases (NONSEQ/SEQ, INCR/WRAP addressing) and counts beats. It drops hreq on the last accepted address phase so the arbiter's burst monitor and hlast logic line up with it.

Parameters:
ADDR_WIDTH, 32, haddr/cmd_addr width
DATA_WIDTH, 32, hwdata/hrdata width; transfers are always word-sized (hsize=3'b010, address step 4)

Ports:
hclk  in  1  bus clock
hreset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered by client
cmd_ready  out  1  high in IDLE only; command accepted on cmd_valid&cmd_ready
cmd_addr  in  ADDR_WIDTH  start address, word aligned
cmd_write  in  1  1=write, 0=read
cmd_burst  in  3  hburst_type: SINGLE=0 INCR=1 WRAP4=2 INCR4=3 WRAP8=4 INCR8=5 WRAP16=6 INCR16=7
cmd_len  in  5  beat count 1..16, used only for INCR (0 treated as 1, >16 clamped to 16)
hreq  out  1  bus request to arbiter
hgrant  in  1  grant from arbiter (already gated by ~hwait)
hwait  in  1  slave stall; 1 = current phases extended
haddr  out  ADDR_WIDTH  address phase address
htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11 (BUSY never driven)
hwrite  out  1  registered command direction
hburst  out  3  registered cmd_burst
hsize  out  3  constant 3'b010
hwdata  out  DATA_WIDTH  equals wdata_in during a write data phase, else 0
hrdata  in  DATA_WIDTH  read data
wdata_in  in  DATA_WIDTH  client write data for the current data phase
wdata_pop  out  1  write data phase completed; client advances its data
rdata_out  out  DATA_WIDTH  hrdata passthrough
rdata_valid  out  1  read data phase completed
done  out  1  one-cycle pulse when the final data phase completes

Behaviour:
- Reset values: state=IDLE, hreq=0, htrans=IDLE, haddr=0, hwrite=0, hburst=SINGLE, wdata_pop=0, rdata_valid=0, done=0, beat counters=0, dphase=0, cmd_ready=1.
- Beat count: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=clamped cmd_len.
- Address acceptance: accept = (state==BURST) & hgrant & ~hwait. Otherwise haddr, htrans, hwrite and hburst hold stable.
- Next address: INCR types use addr+4. WRAPn uses mask = 4n-1 and next = (addr & ~mask) | ((addr+4) & mask).
- Data-phase tracker: dphase is set on accept and cleared when ~hwait with no new accept. dphase_write is registered with it.
- Data-phase completion: dphase & ~hwait. On completion, wdata_pop=1 if write, else rdata_valid=1.
- FSM:
  - IDLE: on cmd_valid, register the command and go to REQ.
  - REQ: hreq=1, htrans=IDLE. When hgrant=1, go to BURST next cycle.
  - BURST: hreq=1. htrans=NONSEQ on beat 0 and SEQ after. On the accept of the last beat, go to TAIL and deassert hreq in the same edge.
  - TAIL: hreq=0, htrans=IDLE. On last data-phase completion, pulse done and go to IDLE.
- Latency: at least 1 cycle from cmd accept to hreq, and at least 1 cycle from hgrant to NONSEQ.
- hwait=1 in BURST or TAIL stalls all counters. Stall length is unbounded.
- hgrant=0 with hwait=0 in BURST means the beat is not accepted. No error is raised; the master keeps presenting the same beat.
- SINGLE: the NONSEQ accept is also the last accept, so the FSM goes directly from BURST to TAIL.
- Commands are not queued: cmd_ready=0 outside IDLE. A new command can be accepted in the cycle after done.
- Reset asserted mid-burst returns all outputs to reset values immediately (asynchronous). The partial burst is discarded and no done pulse is produced.

Test Plan:
- SINGLE write to 0x40 with wdata_in=0xA5A5_0001, grant 2 cycles after hreq: one NONSEQ at 0x40, hwdata=0xA5A5_0001 with wdata_pop=1 one cycle after accept, done next, hreq low after the accept.
- INCR4 read from 0x100, hwait=1 for 2 cycles on beat 2: addresses 0x100/104/108/10C, NONSEQ then SEQ×3, addresses held during the stall, 4 rdata_valid pulses, single done.
- WRAP8 write from 0x1C: address sequence 0x1C,0x00,0x04,0x08,0x0C,0x10,0x14,0x18 and exactly 8 wdata_pop pulses.
- INCR with cmd_len=0 and cmd_len=20: 1 beat and 16 beats respectively.
- hgrant withheld 5 cycles with hwait=0 in BURST: htrans/haddr stable, no accept, burst resumes when hgrant=1.
- Reset pulse during beat 3 of INCR8, then an immediate new SINGLE read: outputs at reset values, no done for the aborted burst, new command completes normally with done=1.
